// File: rtl/eyeriss_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eyeriss_pkg
// Purpose  : Shared types and default sizes for the PE row-convolution slice.
//            Contents: the controller state enum, default width/depth
//            constants, and the full-precision product width helper.
// Revision : 1.0  initial release
// ============================================================================
package eyeriss_pkg;

  localparam int c_DATA_SIZE   = 8;
  localparam int c_PSUM_SIZE   = 20;
  localparam int c_FILT_DEPTH  = 16;
  localparam int c_IFMAP_DEPTH = 16;
  localparam int c_PSUM_DEPTH  = 16;

  // Full-precision width of one filter x ifmap product. A psum narrower than
  // this keeps only the low bits, so accumulation wraps.
  localparam int c_PROD_SIZE = 2 * c_DATA_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD_FILT  = 3'd1,
    ST_LOAD_IFMAP = 3'd2,
    ST_COMPUTE    = 3'd3,
    ST_DRAIN      = 3'd4
  } pe_state_e;

endpackage
`default_nettype wire

// File: rtl/pe_row_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_ctrl_if
// Purpose  : Bundles the load stream, drain stream and the three scratchpad
//            ports of one PE row controller.
// Modports : master - the controller (drives ready/valid-out, spad addr/wr)
//            slave  - the PE surroundings (NoC ports and scratchpads)
// Signals  : in_valid/in_ready/in_data      load stream
//            out_valid/out_ready/out_data   drain stream
//            filt_*, ifmap_*, psum_*        spad addr, wr_en, wr_data, rd_data
// Revision : 1.0  initial release
// ============================================================================
interface pe_row_ctrl_if
  import eyeriss_pkg::*;
#(
  parameter int dataSize   = c_DATA_SIZE,
  parameter int psumSize   = c_PSUM_SIZE,
  parameter int filtDepth  = c_FILT_DEPTH,
  parameter int ifmapDepth = c_IFMAP_DEPTH,
  parameter int psumDepth  = c_PSUM_DEPTH
);

  localparam int c_FILT_AW  = $clog2(filtDepth);
  localparam int c_IFMAP_AW = $clog2(ifmapDepth);
  localparam int c_PSUM_AW  = $clog2(psumDepth);

  logic                  in_valid;
  logic                  in_ready;
  logic [dataSize-1:0]   in_data;

  logic                  out_valid;
  logic                  out_ready;
  logic [psumSize-1:0]   out_data;

  logic [c_FILT_AW-1:0]  filt_addr;
  logic                  filt_wr_en;
  logic [dataSize-1:0]   filt_wr_data;
  logic [dataSize-1:0]   filt_rd_data;

  logic [c_IFMAP_AW-1:0] ifmap_addr;
  logic                  ifmap_wr_en;
  logic [dataSize-1:0]   ifmap_wr_data;
  logic [dataSize-1:0]   ifmap_rd_data;

  logic [c_PSUM_AW-1:0]  psum_addr;
  logic                  psum_wr_en;
  logic [psumSize-1:0]   psum_wr_data;
  logic [psumSize-1:0]   psum_rd_data;

  modport master (
    input  in_valid, in_data, out_ready,
    input  filt_rd_data, ifmap_rd_data, psum_rd_data,
    output in_ready, out_valid, out_data,
    output filt_addr, filt_wr_en, filt_wr_data,
    output ifmap_addr, ifmap_wr_en, ifmap_wr_data,
    output psum_addr, psum_wr_en, psum_wr_data
  );

  modport slave (
    output in_valid, in_data, out_ready,
    output filt_rd_data, ifmap_rd_data, psum_rd_data,
    input  in_ready, out_valid, out_data,
    input  filt_addr, filt_wr_en, filt_wr_data,
    input  ifmap_addr, ifmap_wr_en, ifmap_wr_data,
    input  psum_addr, psum_wr_en, psum_wr_data
  );

endinterface
`default_nettype wire

// File: rtl/pe_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_mac
// Purpose  : Combinational signed multiply-accumulate step for the row
//            controller. psum_out = acc + filt*ifmap (mod 2^psumSize);
//            acc_next is psum_out, or zero when this is the last tap of a
//            window so the next window starts clean.
// Ports    : filt_val, ifmap_val  in   signed dataSize operands
//            acc                  in   current accumulator
//            last                 in   final tap of the current window
//            acc_next             out  value to load into the accumulator
//            psum_out             out  finished partial sum for this tap
// Revision : 1.0  initial release
// ============================================================================
module pe_mac
  import eyeriss_pkg::*;
#(
  parameter int dataSize = c_DATA_SIZE,
  parameter int psumSize = c_PSUM_SIZE
) (
  input  logic [dataSize-1:0] filt_val,
  input  logic [dataSize-1:0] ifmap_val,
  input  logic [psumSize-1:0] acc,
  input  logic                last,
  output logic [psumSize-1:0] acc_next,
  output logic [psumSize-1:0] psum_out
);

  localparam int c_PROD_W = 2 * dataSize;

  logic signed [dataSize-1:0] w_filt;
  logic signed [dataSize-1:0] w_ifmap;
  logic signed [c_PROD_W-1:0] w_prod;
  logic        [psumSize-1:0] w_prod_ext;
  logic        [psumSize-1:0] w_sum;

  assign w_filt  = filt_val;
  assign w_ifmap = ifmap_val;

  // Operands are widened as signed values before the multiply so the full
  // product is exact; the size cast to psumSize then sign-extends (or keeps
  // the low bits when the psum is narrower than the product).
  assign w_prod     = c_PROD_W'(w_filt) * c_PROD_W'(w_ifmap);
  assign w_prod_ext = psumSize'(w_prod);
  assign w_sum      = acc + w_prod_ext;

  assign psum_out = w_sum;
  assign acc_next = last ? '0 : w_sum;

endmodule
`default_nettype wire

// File: rtl/pe_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_row_ctrl
// Purpose  : Sequencer for one PE's 1-D row convolution. Loads S filter
//            words then W ifmap words from the input stream into the spads,
//            runs one MAC per cycle producing E = W-S+1 psums into the psum
//            spad, then drains those psums on an AXI-style output stream.
// Ports    : clk, nrst          clock / asynchronous active-low reset
//            start              begin job (sampled only in IDLE)
//            cfg_s, cfg_w       filter width S, ifmap width W
//            busy               high in every state except IDLE
//            done               one-cycle pulse, coincident with return to IDLE
//            err                one-cycle pulse after a rejected config
//            bus                streams + spad ports (pe_row_ctrl_if.master)
// Revision : 1.0  initial release
// ============================================================================
module pe_row_ctrl
  import eyeriss_pkg::*;
#(
  parameter int dataSize   = c_DATA_SIZE,
  parameter int psumSize   = c_PSUM_SIZE,
  parameter int filtDepth  = c_FILT_DEPTH,
  parameter int ifmapDepth = c_IFMAP_DEPTH,
  parameter int psumDepth  = c_PSUM_DEPTH
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          start,
  input  logic [$clog2(filtDepth):0]    cfg_s,
  input  logic [$clog2(ifmapDepth):0]   cfg_w,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  pe_row_ctrl_if.master                 bus
);

  localparam int c_FILT_AW  = $clog2(filtDepth);
  localparam int c_IFMAP_AW = $clog2(ifmapDepth);
  localparam int c_PSUM_AW  = $clog2(psumDepth);

  pe_state_e             r_state;
  logic [c_FILT_AW-1:0]  r_s;        // filter load index, then tap index s
  logic [c_FILT_AW-1:0]  r_s_last;   // S-1
  logic [c_IFMAP_AW-1:0] r_x;        // ifmap load index
  logic [c_IFMAP_AW-1:0] r_w_last;   // W-1
  logic [c_PSUM_AW-1:0]  r_e;        // output index e, then drain index d
  logic [c_PSUM_AW-1:0]  r_e_last;   // E-1
  logic [psumSize-1:0]   r_acc;
  logic                  r_done;
  logic                  r_err;

  logic [31:0]           w_s32;
  logic [31:0]           w_w32;
  logic [31:0]           w_e32;
  logic                  w_cfg_bad;
  logic                  w_tap_last;
  logic [c_IFMAP_AW-1:0] w_win_addr;
  logic [psumSize-1:0]   w_acc_next;
  logic [psumSize-1:0]   w_psum_out;

  // Config legality is judged in 32 bits so E = W-S+1 cannot alias when S>W.
  assign w_s32     = 32'(cfg_s);
  assign w_w32     = 32'(cfg_w);
  assign w_e32     = w_w32 - w_s32 + 32'd1;
  assign w_cfg_bad = (w_s32 == 32'd0)
                  || (w_s32 > w_w32)
                  || (w_w32 > 32'(ifmapDepth))
                  || (w_s32 > 32'(filtDepth))
                  || (w_e32 > 32'(psumDepth));

  assign w_tap_last = (r_s == r_s_last);
  assign w_win_addr = c_IFMAP_AW'(r_e) + c_IFMAP_AW'(r_s);

  pe_mac #(
    .dataSize (dataSize),
    .psumSize (psumSize)
  ) u_mac (
    .filt_val  (bus.filt_rd_data),
    .ifmap_val (bus.ifmap_rd_data),
    .acc       (r_acc),
    .last      (w_tap_last),
    .acc_next  (w_acc_next),
    .psum_out  (w_psum_out)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= ST_IDLE;
      r_s      <= '0;
      r_s_last <= '0;
      r_x      <= '0;
      r_w_last <= '0;
      r_e      <= '0;
      r_e_last <= '0;
      r_acc    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_s_last <= c_FILT_AW'(w_s32 - 32'd1);
            r_w_last <= c_IFMAP_AW'(w_w32 - 32'd1);
            r_e_last <= c_PSUM_AW'(w_e32 - 32'd1);
            r_s      <= '0;
            r_x      <= '0;
            r_e      <= '0;
            r_acc    <= '0;
            if (w_cfg_bad) begin
              r_err <= 1'b1;
            end else begin
              r_state <= ST_LOAD_FILT;
            end
          end
        end
        ST_LOAD_FILT: begin
          if (bus.in_valid) begin
            if (w_tap_last) begin
              r_s     <= '0;
              r_state <= ST_LOAD_IFMAP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end
        end
        ST_LOAD_IFMAP: begin
          if (bus.in_valid) begin
            if (r_x == r_w_last) begin
              r_x     <= '0;
              r_state <= ST_COMPUTE;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          r_acc <= w_acc_next;
          if (w_tap_last) begin
            r_s <= '0;
            if (r_e == r_e_last) begin
              r_e     <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_e <= r_e + 1'b1;
            end
          end else begin
            r_s <= r_s + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (bus.out_ready) begin
            if (r_e == r_e_last) begin
              r_e     <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_e <= r_e + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

  // Every counter is returned to zero when its phase ends, so the address
  // outputs read back as zero in IDLE without extra gating.
  assign bus.in_ready      = (r_state == ST_LOAD_FILT) || (r_state == ST_LOAD_IFMAP);
  assign bus.filt_addr     = r_s;
  assign bus.filt_wr_en    = (r_state == ST_LOAD_FILT) && bus.in_valid;
  assign bus.filt_wr_data  = bus.in_data;
  assign bus.ifmap_addr    = (r_state == ST_COMPUTE) ? w_win_addr : r_x;
  assign bus.ifmap_wr_en   = (r_state == ST_LOAD_IFMAP) && bus.in_valid;
  assign bus.ifmap_wr_data = bus.in_data;
  assign bus.psum_addr     = r_e;
  assign bus.psum_wr_en    = (r_state == ST_COMPUTE) && w_tap_last;
  assign bus.psum_wr_data  = w_psum_out;

  // The drain index only moves on a handshake and the psum spad is not
  // written while draining, so out_data holds steady during a stall.
  assign bus.out_valid = (r_state == ST_DRAIN);
  assign bus.out_data  = bus.psum_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_pe_row_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_row_ctrl
// Purpose  : Self-checking bench for pe_row_ctrl. Two controllers (20-bit and
//            8-bit psums) run the same jobs in lockstep against behavioural
//            spad models; psums are checked against a plain-arithmetic
//            convolution reference, plus timing, handshake and error rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_pe_row_ctrl;
  import eyeriss_pkg::*;

  localparam int DS  = 8;
  localparam int PS  = 20;
  localparam int PS8 = 8;
  localparam int FD  = 16;
  localparam int ID  = 16;
  localparam int PD  = 16;
  localparam int SW  = $clog2(FD) + 1;
  localparam int WW  = $clog2(ID) + 1;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] cfg_s = '0;
  logic [WW-1:0] cfg_w = '0;
  logic          in_valid = 1'b0;
  logic [DS-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          busy, done, err;
  logic          busy8, done8, err8;

  always #5 clk = ~clk;

  pe_row_ctrl_if #(.dataSize(DS), .psumSize(PS), .filtDepth(FD),
                   .ifmapDepth(ID), .psumDepth(PD)) bus ();
  pe_row_ctrl_if #(.dataSize(DS), .psumSize(PS8), .filtDepth(FD),
                   .ifmapDepth(ID), .psumDepth(PD)) bus8 ();

  pe_row_ctrl #(.dataSize(DS), .psumSize(PS), .filtDepth(FD),
                .ifmapDepth(ID), .psumDepth(PD)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .cfg_s(cfg_s), .cfg_w(cfg_w),
    .busy(busy), .done(done), .err(err), .bus(bus));

  pe_row_ctrl #(.dataSize(DS), .psumSize(PS8), .filtDepth(FD),
                .ifmapDepth(ID), .psumDepth(PD)) u_dut8 (
    .clk(clk), .nrst(nrst), .start(start), .cfg_s(cfg_s), .cfg_w(cfg_w),
    .busy(busy8), .done(done8), .err(err8), .bus(bus8));

  // Shared stimulus to both controllers
  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.out_ready  = out_ready;
  assign bus8.in_valid  = in_valid;
  assign bus8.in_data   = in_data;
  assign bus8.out_ready = out_ready;

  // Scratchpad models: combinational read, synchronous write
  logic [DS-1:0]  filt_m  [FD];
  logic [DS-1:0]  ifmap_m [ID];
  logic [PS-1:0]  psum_m  [PD];
  logic [DS-1:0]  filt_m8 [FD];
  logic [DS-1:0]  ifmap_m8[ID];
  logic [PS8-1:0] psum_m8 [PD];

  assign bus.filt_rd_data   = filt_m[bus.filt_addr];
  assign bus.ifmap_rd_data  = ifmap_m[bus.ifmap_addr];
  assign bus.psum_rd_data   = psum_m[bus.psum_addr];
  assign bus8.filt_rd_data  = filt_m8[bus8.filt_addr];
  assign bus8.ifmap_rd_data = ifmap_m8[bus8.ifmap_addr];
  assign bus8.psum_rd_data  = psum_m8[bus8.psum_addr];

  always @(posedge clk) begin
    if (bus.filt_wr_en)   filt_m[bus.filt_addr]     <= bus.filt_wr_data;
    if (bus.ifmap_wr_en)  ifmap_m[bus.ifmap_addr]   <= bus.ifmap_wr_data;
    if (bus.psum_wr_en)   psum_m[bus.psum_addr]     <= bus.psum_wr_data;
    if (bus8.filt_wr_en)  filt_m8[bus8.filt_addr]   <= bus8.filt_wr_data;
    if (bus8.ifmap_wr_en) ifmap_m8[bus8.ifmap_addr] <= bus8.ifmap_wr_data;
    if (bus8.psum_wr_en)  psum_m8[bus8.psum_addr]   <= bus8.psum_wr_data;
  end

  // Event counters sampled mid-cycle
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  always @(negedge clk) begin
    wr_cnt <= wr_cnt + int'(bus.filt_wr_en) + int'(bus.ifmap_wr_en)
                     + int'(bus.psum_wr_en) + int'(bus8.filt_wr_en)
                     + int'(bus8.ifmap_wr_en) + int'(bus8.psum_wr_en);
    if (done) done_cnt <= done_cnt + 1;
    if (err)  err_cnt  <= err_cnt + 1;
  end

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference job data
  int f_ref[16];
  int x_ref[16];

  function automatic int psum_ref(input int e, input int s);
    int acc = 0;
    for (int k = 0; k < s; k++) acc += f_ref[k] * x_ref[e + k];
    return acc;
  endfunction

  task automatic fill_rand(input int s, input int w);
    for (int k = 0; k < s; k++) f_ref[k] = int'($urandom_range(255)) - 128;
    for (int k = 0; k < w; k++) x_ref[k] = int'($urandom_range(255)) - 128;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int s, input int w);
    start = 1'b1;
    cfg_s = SW'(s);
    cfg_w = WW'(w);
    tick();
    start = 1'b0;
  endtask

  task automatic load_job(input int s, input int w, input int gap);
    int n = s + w;
    int idx = 0;
    int guard = 0;
    while (idx < n && guard < 2000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = DS'((idx < s) ? f_ref[idx] : x_ref[idx - s]);
      if (in_valid && bus.in_ready) idx++;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    check("load_beats", idx, n);
  endtask

  task automatic finish_job(input int s, input int w, input int stall, input int d0);
    int e = w - s + 1;
    int cyc = 0;
    int got = 0;
    int guard = 0;
    bit stalled = 1'b0;
    logic [PS-1:0]  prev20 = '0;
    logic [PS8-1:0] prev8 = '0;
    int r;
    while (!bus.out_valid && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("compute_cycles", cyc, s * e);
    while (got < e && guard < 4000) begin
      if (stalled) begin
        check("stall_hold20", bus.out_data, prev20);
        check("stall_hold8", bus8.out_data, prev8);
      end
      out_ready = ($urandom_range(99) >= stall);
      if (bus.out_valid && out_ready) begin
        r = psum_ref(got, s);
        check($sformatf("psum20[%0d]", got), bus.out_data, 32'(r) & 32'h000F_FFFF);
        check($sformatf("psum8[%0d]", got), bus8.out_data, 32'(r) & 32'h0000_00FF);
        got++;
      end
      stalled = bus.out_valid && !out_ready;
      prev20  = bus.out_data;
      prev8   = bus8.out_data;
      tick();
      guard++;
    end
    out_ready = 1'b0;
    check("drain_beats", got, e);
    if (stall == 0) check("drain_cycles", guard, e);
    check("done_pulse", {done, done8, busy, busy8}, 4'b1100);
    tick();
    check("done_low", {done, done8}, 2'b00);
    check("done_count", done_cnt - d0, 1);
  endtask

  task automatic run_job(input int s, input int w, input int gap, input int stall);
    int d0 = done_cnt;
    start_job(s, w);
    check("busy_rise", {busy, busy8}, 2'b11);
    load_job(s, w, gap);
    finish_job(s, w, stall, d0);
  endtask

  task automatic illegal_job(input int s, input int w);
    int w0 = wr_cnt;
    int e0 = err_cnt;
    start_job(s, w);
    check($sformatf("err_pulse_s%0d_w%0d", s, w), {err, err8, busy, busy8}, 4'b1100);
    tick();
    check("err_low", {err, busy}, 2'b00);
    tick();
    check("err_count", err_cnt - e0, 1);
    check("err_no_wr", wr_cnt - w0, 0);
  endtask

  function automatic logic [31:0] idle_outs();
    return 32'({busy, done, err, bus.in_ready, bus.out_valid, bus.filt_wr_en,
                bus.ifmap_wr_en, bus.psum_wr_en, bus.filt_addr, bus.ifmap_addr,
                bus.psum_addr, busy8, bus8.psum_wr_en, bus8.in_ready});
  endfunction

  initial begin
    int s, w, w0;
    nrst = 1'b0;
    tick();
    tick();
    check("reset_outs", idle_outs(), 32'd0);
    nrst = 1'b1;
    tick();

    // Basic row
    f_ref[0] = 1; f_ref[1] = 2; f_ref[2] = 3;
    for (int k = 0; k < 5; k++) x_ref[k] = 1;
    run_job(3, 5, 0, 0);

    // Signed operands
    f_ref[0] = -1; f_ref[1] = 2;
    x_ref[0] = 3; x_ref[1] = -4; x_ref[2] = 5;
    run_job(2, 3, 0, 0);

    // Accumulator wrap, visible on the 8-bit instance
    f_ref[0] = 127; f_ref[1] = 127;
    x_ref[0] = 127; x_ref[1] = 127; x_ref[2] = 0;
    run_job(2, 3, 0, 0);

    // Boundaries: S==W (E=1), S==1, full-size filter, full-size output
    fill_rand(4, 4);   run_job(4, 4, 0, 0);
    fill_rand(1, 7);   run_job(1, 7, 0, 0);
    fill_rand(16, 16); run_job(16, 16, 20, 20);
    fill_rand(1, 16);  run_job(1, 16, 0, 30);

    // Random jobs with input gaps and output stalls
    for (int j = 0; j < 6; j++) begin
      s = int'($urandom_range(8, 1));
      w = int'($urandom_range(16, s));
      fill_rand(s, w);
      run_job(s, w, 30, 40);
    end

    // Rejected configurations
    illegal_job(0, 5);
    illegal_job(6, 5);
    illegal_job(3, 17);

    // Reset in the middle of COMPUTE
    fill_rand(4, 10);
    start_job(4, 10);
    load_job(4, 10, 0);
    repeat (5) tick();
    nrst = 1'b0;
    #1;
    check("rst_mid_outs", idle_outs(), 32'd0);
    w0 = wr_cnt;
    tick();
    nrst = 1'b1;
    tick();
    tick();
    check("rst_mid_no_wr", wr_cnt - w0, 0);
    check("rst_mid_idle", {busy, busy8}, 2'b00);

    // A legal job after the abort must be correct
    fill_rand(3, 9);
    run_job(3, 9, 25, 25);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
